// File: rtl/inst_fetch.sv
// Instruction fetch stage: program counter, ROM request (chip_en/inst_addr)
// and the IF/ID pipeline register feeding decode. The ROM answers
// combinationally, so the word on inst_i belongs to the current inst_addr.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic [31:0] inst_i,
  output logic        chip_en,
  output logic [31:0] inst_addr,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Sequential PC advance; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  logic        chip_en_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        hold_pc;
  logic        hold_ifid;
  logic        bubble;

  // The illegal 2'b10 stall code is treated as 2'b11: any hold of IF/ID
  // also holds the PC, so the held instruction is not lost or skipped.
  assign hold_pc   = stall[0] | stall[1];
  assign hold_ifid = stall[1];
  assign bubble    = stall[0] & ~stall[1];

  // ROM enable comes up one edge after reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      chip_en_q <= 1'b0;
    end else begin
      chip_en_q <= 1'b1;
    end
  end

  // Next-PC select: flush beats stall, stall beats branch (a branch seen
  // while stalled is dropped; decode re-presents it), else sequential.
  always_comb begin
    pc_d = pc_inc(pc_q);
    if (flush) begin
      pc_d = word_align(flush_pc);
    end else if (hold_pc) begin
      pc_d = pc_q;
    end else if (branch_flag) begin
      pc_d = word_align(branch_target);
    end
  end

  // PC register; parked at RESET_PC until the ROM is enabled.
  always_ff @(posedge clk) begin
    if (rst || !chip_en_q) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF/ID next state: flush clears, stall[1] holds, stall[0] inserts a
  // bubble, otherwise capture the word fetched this cycle. The instruction
  // after a branch is passed through unchanged as the delay slot.
  always_comb begin
    id_pc_d   = 32'd0;
    id_inst_d = 32'd0;
    if (flush) begin
      id_pc_d   = 32'd0;
      id_inst_d = 32'd0;
    end else if (hold_ifid) begin
      id_pc_d   = id_pc_q;
      id_inst_d = id_inst_q;
    end else if (bubble) begin
      id_pc_d   = 32'd0;
      id_inst_d = 32'd0;
    end else if (chip_en_q) begin
      id_pc_d   = pc_q;
      id_inst_d = inst_i;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_q   <= 32'd0;
      id_inst_q <= 32'd0;
    end else begin
      id_pc_q   <= id_pc_d;
      id_inst_q <= id_inst_d;
    end
  end

  assign chip_en   = chip_en_q;
  assign inst_addr = pc_q;
  assign id_pc     = id_pc_q;
  assign id_inst   = id_inst_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a behavioural ROM (word[k] = k+1) answers the
// fetch port; per-cycle stimulus records carry the outputs expected after
// the following rising edge, queued when driven and compared once sampled.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [1:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] inst_i;
  logic        chip_en;
  logic [31:0] inst_addr;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  inst_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .inst_i        (inst_i),
    .chip_en       (chip_en),
    .inst_addr     (inst_addr),
    .id_pc         (id_pc),
    .id_inst       (id_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM indexed by word bits [18:2]; zero when disabled.
  always_comb begin
    inst_i = 32'd0;
    if (chip_en) inst_i = {15'd0, inst_addr[18:2]} + 32'd1;
  end

  typedef struct {
    logic        rst;
    logic [1:0]  stall;
    logic        bf;
    logic [31:0] bt;
    logic        fl;
    logic [31:0] fpc;
    logic        e_ce;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  typedef struct {
    int          row;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  function automatic vec_t mk(input logic r, input logic [1:0] s,
                              input logic bf, input logic [31:0] bt,
                              input logic fl, input logic [31:0] fpc,
                              input logic ce, input logic [31:0] addr,
                              input logic [31:0] pc, input logic [31:0] inst);
    vec_t v;
    v.rst = r; v.stall = s; v.bf = bf; v.bt = bt; v.fl = fl; v.fpc = fpc;
    v.e_ce = ce; v.e_addr = addr; v.e_pc = pc; v.e_inst = inst;
    return v;
  endfunction

  task automatic check32(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s row %0d: got %h, required %h", name, row, act, req);
  endtask

  // Drive one cycle of stimulus, queue its expectation, then sample #1
  // after the edge and retire the oldest expectation.
  task automatic step(input vec_t v, input int row);
    exp_t e;
    exp_t got;
    rst           = v.rst;
    stall         = v.stall;
    branch_flag   = v.bf;
    branch_target = v.bt;
    flush         = v.fl;
    flush_pc      = v.fpc;
    e.row = row; e.ce = v.e_ce; e.addr = v.e_addr; e.pc = v.e_pc; e.inst = v.e_inst;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total_cnt++;
      $display("FAIL scoreboard row %0d: got empty queue, required one entry", row);
    end else begin
      got = sb.pop_front();
      check32("chip_en",   got.row, {31'd0, chip_en}, {31'd0, got.ce});
      check32("inst_addr", got.row, inst_addr, got.addr);
      check32("id_pc",     got.row, id_pc,     got.pc);
      check32("id_inst",   got.row, id_inst,   got.inst);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 2'b00; branch_flag = 1'b0; branch_target = 32'd0;
    flush = 1'b0; flush_pc = 32'd0;

    //            rst stall bf bt            fl fpc     ce addr          id_pc         id_inst
    // reset, then free run
    tbl.push_back(mk(1, 2'b00, 0, 32'h0,        0, 32'h0,  0, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk(1, 2'b00, 0, 32'h0,        0, 32'h0,  0, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk(1, 2'b00, 0, 32'h0,        0, 32'h0,  0, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,  1, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,  1, 32'h4,        32'h0,        32'h1));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,  1, 32'h8,        32'h4,        32'h2));
    // full stall for two cycles at inst_addr=8, then resume
    tbl.push_back(mk(0, 2'b11, 0, 32'h0,        0, 32'h0,  1, 32'h8,        32'h4,        32'h2));
    tbl.push_back(mk(0, 2'b11, 0, 32'h0,        0, 32'h0,  1, 32'h8,        32'h4,        32'h2));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,  1, 32'hC,        32'h8,        32'h3));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,  1, 32'h10,       32'hC,        32'h4));
    // branch at 16: first under stall[0] (PC held, bubble), then taken
    tbl.push_back(mk(0, 2'b01, 1, 32'h103,      0, 32'h0,  1, 32'h10,       32'h0,        32'h0));
    tbl.push_back(mk(0, 2'b00, 1, 32'h103,      0, 32'h0,  1, 32'h100,      32'h10,       32'h5));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,  1, 32'h104,      32'h100,      32'h41));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,  1, 32'h108,      32'h104,      32'h42));
    // flush and branch on the same edge: flush wins
    tbl.push_back(mk(0, 2'b00, 1, 32'h300,      1, 32'h20, 1, 32'h20,       32'h0,        32'h0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,  1, 32'h24,       32'h20,       32'h9));
    // branch back to 8 (target low bits set), then one-cycle bubble
    tbl.push_back(mk(0, 2'b00, 1, 32'hA,        0, 32'h0,  1, 32'h8,        32'h24,       32'hA));
    tbl.push_back(mk(0, 2'b01, 0, 32'h0,        0, 32'h0,  1, 32'h8,        32'h0,        32'h0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,  1, 32'hC,        32'h8,        32'h3));
    // branch to the top word, PC wraps to 0
    tbl.push_back(mk(0, 2'b00, 1, 32'hFFFF_FFFF, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'hC,        32'h4));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,  1, 32'h0,        32'hFFFF_FFFC, 32'h2_0000));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,  1, 32'h4,        32'h0,        32'h1));
    // illegal stall 2'b10 behaves as 2'b11
    tbl.push_back(mk(0, 2'b10, 0, 32'h0,        0, 32'h0,  1, 32'h4,        32'h0,        32'h1));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,  1, 32'h8,        32'h4,        32'h2));
    // flush overrides a full stall
    tbl.push_back(mk(0, 2'b11, 0, 32'h0,        1, 32'h42, 1, 32'h40,       32'h0,        32'h0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,  1, 32'h44,       32'h40,       32'h11));
    // mid-stream reset with a branch pending
    tbl.push_back(mk(1, 2'b00, 1, 32'h200,      0, 32'h0,  0, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,  1, 32'h0,        32'h0,        32'h0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,  1, 32'h4,        32'h0,        32'h1));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Hand-written: a branch seen only while stalled is not remembered.
    step(mk(0, 2'b01, 1, 32'h500, 0, 32'h0, 1, 32'h4, 32'h0, 32'h0), 100);
    step(mk(0, 2'b00, 0, 32'h0,   0, 32'h0, 1, 32'h8, 32'h4, 32'h2), 101);

    // Hand-written: two back-to-back branches; each delay slot passes through.
    step(mk(0, 2'b00, 1, 32'h80,  0, 32'h0, 1, 32'h80,  32'h8,  32'h3),  102);
    step(mk(0, 2'b00, 1, 32'h10,  0, 32'h0, 1, 32'h10,  32'h80, 32'h21), 103);
    step(mk(0, 2'b00, 0, 32'h0,   0, 32'h0, 1, 32'h14,  32'h10, 32'h5),  104);

    if (sb.size() != 0) begin
      total_cnt++;
      $display("FAIL scoreboard drain: got %0d entries left, required 0", sb.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage: owns the program counter, drives the chip enable and word address into the instruction ROM, and captures the returned instruction into the IF/ID pipeline register for decode. It is the requesting end of the ROM fetch interface. The ROM returns the instruction combinationally in the same cycle the address is presented, with zero when disabled. The block also handles pipeline stalls, branch redirects and exception flushes.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- stall  input  2  [0] hold PC; [1] hold IF/ID register.
- branch_flag  input  1  redirect request from decode.
- branch_target  input  32  redirect address.
- flush  input  1  exception flush request.
- flush_pc  input  32  exception handler address.
- inst_i  input  32  instruction word returned by ROM.
- chip_en  output  1  ROM chip enable.
- inst_addr  output  32  byte address to ROM; ROM indexes word bits [18:2].
- id_pc  output  32  PC of the instruction held in IF/ID.
- id_inst  output  32  instruction held in IF/ID; 0 is a bubble (nop).

## Operation
- chip_en register: 0 while rst; 1 from the first clock after rst deasserts.
- PC register (drives inst_addr):
  - rst or chip_en==0 → PC = RESET_PC.
  - Otherwise the next PC is chosen by priority: flush → {flush_pc[31:2],2'b00}; else stall[0] → hold; else branch_flag → {branch_target[31:2],2'b00}; else PC+4.
- Addresses are word aligned. Target bits [1:0] are forced to 0. PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- A stall beats a branch. Decode must keep branch_flag asserted until stall[0] releases. A branch seen while stalled is not remembered.
- The PC+4 instruction following a branch is fetched and passed to decode as the delay slot. No extra squash is applied.
- IF/ID register, by priority:
  - rst or flush → id_pc=0, id_inst=0.
  - stall[1] → hold.
  - stall[0] & ~stall[1] → bubble: id_pc=0, id_inst=0.
  - else, if chip_en → id_pc=PC, id_inst=inst_i.
  - else → id_pc=0, id_inst=0.
- stall[1]=1 with stall[0]=0 is illegal from the controller. The required response is to hold both PC and IF/ID, i.e. treat it as 2'b11.
- Reset asserted mid-operation overrides everything on that edge: every output returns to its reset value on the next edge.

## Timing
- Reset values: chip_en=0, inst_addr=RESET_PC, id_pc=0, id_inst=0.
- Edge E0 is the first edge with rst=0:
  - After E0: chip_en=1, inst_addr=RESET_PC; IF/ID loads 0 at E0.
  - After E1: id_inst=mem[RESET_PC], inst_addr=RESET_PC+4.
- Fetch latency is 1 cycle: the address presented in cycle N appears on id_inst after edge N.
- Redirect latency: branch_flag or flush sampled at edge N → inst_addr=target after edge N; the target instruction is in IF/ID after edge N+1.
- Throughput is one instruction per cycle when unstalled.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset then free run: rst high 3 cycles then low, ROM word[k]=k+1.
  - Required: inst_addr=0,4,8,12…
  - Required: id_inst=0, then 1,2,3 on successive edges.
  - Required: chip_en 0→1 exactly one edge after rst falls.
- Stall: stall=2'b11 for 2 cycles while inst_addr=8. Required: inst_addr and id_inst/id_pc frozen, then sequence resumes at 12 with no skipped or duplicated word.
- Bubble: stall=2'b01 for one cycle at inst_addr=8. Required: id_inst=0, id_pc=0 that cycle; inst_addr stays 8; next id_inst=mem[8].
- Branch: branch_flag=1, branch_target=32'h0000_0103 while inst_addr=16.
  - Required: next inst_addr=32'h100; id_inst shows mem[16] (delay slot) then mem[0x100].
  - Required: the same request under stall[0]=1 leaves PC held.
- Flush vs branch: flush=1, flush_pc=32'h20, branch_flag=1 on the same edge. Required: inst_addr=32'h20, id_inst=0, id_pc=0; next id_inst=mem[0x20].
- Wrap and mid-run reset:
  - Branch to 32'hFFFF_FFFC. Required: next inst_addr=0.
  - Then assert rst for 1 cycle mid-stream. Required: chip_en=0, inst_addr=RESET_PC, id_inst=0 after that edge.
